cpci_pci2net_16x60_fifo: RTL and testbench
==========================================

Name: cpci_pci2net_16x60_fifo

Overview:
Single-clock 16-entry x 60-bit synchronous FIFO carrying CPCI->CNET register requests, packed as {we[59], addr[58:32], data[31:0]}. The writer pushes requests with wrreq. The register-interface state machine pops them with rdreq, in normal (non-show-ahead) read mode. Provides full, almost_full and empty flags, with overflow and underflow protection.

Parameters:
WIDTH, 60, word width in bits (1 + 27 address bits + 32 data bits)
DEPTH, 16, number of entries; must be a power of 2
ADDR_W, 4, log2(DEPTH); pointer width
AF_THRESH, 12, almost_full asserts when occupancy >= AF_THRESH

Ports:
clock  in  1  single clock; all state changes on its rising edge
aclr_n  in  1  asynchronous active-low clear; empties the FIFO
data  in  WIDTH  write word
wrreq  in  1  write request; word is accepted when full=0
rdreq  in  1  read request; word is popped when empty=0
q  out  WIDTH  read data; registered, valid the cycle after an accepted read
empty  out  1  occupancy == 0
full  out  1  occupancy == DEPTH
almost_full  out  1  occupancy >= AF_THRESH

Behaviour:
- State: a DEPTH x WIDTH storage array, a write pointer, a read pointer, and an occupancy counter (ADDR_W+1 bits, range 0..DEPTH).
- Reset: aclr_n low clears all of the following immediately, without waiting for clock: pointers = 0, occupancy = 0, q = 0, empty = 1, full = 0, almost_full = 0. Storage contents are not cleared. Release of aclr_n is synchronised internally.
- Write: on a clock edge with wrreq=1 and full=0:
  - mem[wptr] <= data; wptr increments, wrapping modulo DEPTH.
  - wrreq while full is ignored: no pointer or occupancy change, data dropped, no error output.
- Read: on a clock edge with rdreq=1 and empty=0:
  - q <= mem[rptr]; rptr increments, wrapping modulo DEPTH.
  - q is stable from the cycle after the read until the next accepted read.
  - rdreq while empty is ignored: q holds its value and rptr is unchanged.
- Simultaneous wrreq and rdreq:
  - Neither full nor empty: both are performed and occupancy is unchanged.
  - When empty: only the write is performed; occupancy becomes 1 and q is not updated.
  - When full: only the read is performed; occupancy becomes DEPTH-1 and the incoming word is dropped.
- Flags are derived from the registered occupancy and update on the same edge as the accepted operation, so each has one cycle of latency relative to the request.
  - After the first write into an empty FIFO, empty falls at the next edge.
  - full rises on the edge that accepts the 16th word.
- Read-during-write to the same address cannot occur while empty=0 under the ordering above. No bypass path exists, so a word is never readable in its write cycle.
- Sizing: ordering is strictly FIFO. Pointers wrap silently; full is resolved by the occupancy counter, not by pointer comparison.

Decomposition:
- Shared package: CPCI_CNET_DATA_WIDTH = 32, CPCI_CNET_ADDR_WIDTH = 27, and the packed field offsets (WE_BIT = 59, ADDR_MSB = 58, ADDR_LSB = 32).
- One sub-module is natural: fifo_ram_16x60, a simple dual-port RAM with a synchronous write port and a registered read port. Pointer, occupancy and flag logic stay in the top module.

Test Plan:
- Reset: pulse aclr_n low mid-clock with 5 entries stored -> empty=1, full=0, almost_full=0 and q=0 immediately; a subsequent rdreq leaves q=0.
- Ordered fill/drain: write 0x0_0000001_00000001 through ..._00000010 (16 words).
  - almost_full rises after the 12th write; full rises after the 16th.
  - 16 reads return the words in order, each on q one cycle after its rdreq; empty rises after the 16th read.
- Overflow: with the FIFO full, write 0xFFF_FFFF_FFFF_FFFF -> full stays 1 and occupancy stays 16; draining never returns the dropped word.
- Underflow: with the FIFO empty and q=0xABC, assert rdreq for 3 cycles -> q stays 0xABC and empty stays 1.
- Simultaneous operations:
  - Empty FIFO, wrreq+rdreq together with data=0x5 -> next cycle empty=0, q unchanged; the next rdreq returns 0x5.
  - Full FIFO, wrreq+rdreq together -> head word appears on q, full=0, and the new word is not stored.
- Wrap-around: stream 40 words with random interleaved wrreq/rdreq, keeping occupancy at 8 or below -> all 40 are read back in order with no loss, confirming pointer wrap.

Source files
------------

// File: rtl/cpci_pci2net_16x60_fifo_pkg.sv
// Shared constants for the CPCI->CNET register request FIFO.
// A request word is packed as {we, addr[26:0], data[31:0]}.
package cpci_pci2net_16x60_fifo_pkg;

  localparam int unsigned CPCI_CNET_DATA_WIDTH = 32;
  localparam int unsigned CPCI_CNET_ADDR_WIDTH = 27;

  // Bit positions of the fields inside a packed request word
  localparam int unsigned WE_BIT   = 59;
  localparam int unsigned ADDR_MSB = 58;
  localparam int unsigned ADDR_LSB = 32;

  localparam int unsigned FIFO_WIDTH     = 1 + CPCI_CNET_ADDR_WIDTH + CPCI_CNET_DATA_WIDTH;
  localparam int unsigned FIFO_DEPTH     = 16;
  localparam int unsigned FIFO_ADDR_W    = 4;
  localparam int unsigned FIFO_AF_THRESH = 12;

  typedef struct packed {
    logic                            we;
    logic [CPCI_CNET_ADDR_WIDTH-1:0] addr;
    logic [CPCI_CNET_DATA_WIDTH-1:0] data;
  } cnet_req_t;

  // Build a packed request word from its fields
  function automatic logic [FIFO_WIDTH-1:0] pack_req(
    input logic                            we,
    input logic [CPCI_CNET_ADDR_WIDTH-1:0] addr,
    input logic [CPCI_CNET_DATA_WIDTH-1:0] data
  );
    cnet_req_t req;
    req.we   = we;
    req.addr = addr;
    req.data = data;
    return req;
  endfunction

endpackage

// File: rtl/fifo_ram_16x60.sv
// Simple dual-port RAM: synchronous write port, registered read port.
// Storage is never cleared; only the read register is reset.
module fifo_ram_16x60 #(
  parameter int unsigned WIDTH  = 60,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port: store the word at wr_addr
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the addressed word, hold it until the next read
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cpci_pci2net_16x60_fifo.sv
// 16 x 60 synchronous FIFO for CPCI->CNET register requests, normal
// (non-show-ahead) read mode. Occupancy counter resolves full/empty.
module cpci_pci2net_16x60_fifo
  import cpci_pci2net_16x60_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_WIDTH,
  parameter int unsigned DEPTH     = FIFO_DEPTH,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AF_THRESH = FIFO_AF_THRESH
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  localparam logic [ADDR_W:0] DepthLvl = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AfLvl    = AF_THRESH[ADDR_W:0];

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_ok, rd_ok;

  // Reset synchroniser: asserts immediately, releases two edges later
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Accept qualifiers: drop writes when full, ignore reads when empty
  always_comb begin
    wr_ok = wrreq & ~full;
    rd_ok = rdreq & ~empty;
  end

  // Next-state for pointers and occupancy
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) begin
      wptr_d = wptr_q + ADDR_W'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + ADDR_W'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Flags decode the registered occupancy
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == DepthLvl);
    almost_full = (count_q >= AfLvl);
  end

  fifo_ram_16x60 #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wptr_q),
    .wr_data (data),
    .rd_en   (rd_ok),
    .rd_addr (rptr_q),
    .rd_data (q)
  );

endmodule

// File: tb/tb_cpci_pci2net_16x60_fifo.sv
// Self-checking bench for cpci_pci2net_16x60_fifo with a queue scoreboard.
module tb_cpci_pci2net_16x60_fifo;

  localparam int unsigned W = 60;

  logic         clock;
  logic         aclr_n;
  logic [W-1:0] data;
  logic         wrreq;
  logic         rdreq;
  logic [W-1:0] q;
  logic         empty;
  logic         full;
  logic         almost_full;

  int n_checks;
  int n_fail;

  logic [W-1:0] sb[$];
  logic [W-1:0] exp_q;

  cpci_pci2net_16x60_fifo dut (
    .clock       (clock),
    .aclr_n      (aclr_n),
    .data        (data),
    .wrreq       (wrreq),
    .rdreq       (rdreq),
    .q           (q),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".empty"}, 64'(empty), 64'(sb.size() == 0));
    check({tag, ".full"}, 64'(full), 64'(sb.size() == 16));
    check({tag, ".af"}, 64'(almost_full), 64'(sb.size() >= 12));
    check({tag, ".q"}, 64'(q), 64'(exp_q));
  endtask

  // One clock with the given requests; model decides acceptance from pre-edge state
  task automatic step(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    bit wacc, racc;
    wrreq = w;
    rdreq = r;
    data  = d;
    wacc  = w && (sb.size() < 16);
    racc  = r && (sb.size() > 0);
    @(posedge clock);
    #1;
    if (racc) exp_q = sb.pop_front();
    if (wacc) sb.push_back(d);
    check_flags(tag);
    @(negedge clock);
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    aclr_n = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int written, rd_cnt, budget;
    logic [W-1:0] next_w;
    n_checks = 0;
    n_fail   = 0;
    aclr_n   = 1'b0;
    wrreq    = 1'b0;
    rdreq    = 1'b0;
    data     = '0;
    exp_q    = '0;
    #12;
    check_flags("por");
    release_reset();
    check_flags("post_release");

    // Six writes and one read leave five stored and q nonzero
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 60'h0_0000002_00000000 | W'(i + 1), "pre_rst_wr");
    step(1'b0, 1'b1, '0, "pre_rst_rd");

    // Mid-cycle asynchronous clear
    @(posedge clock);
    #2;
    aclr_n = 1'b0;
    #1;
    sb.delete();
    exp_q = '0;
    check_flags("async_clr");
    release_reset();
    step(1'b0, 1'b1, '0, "rd_after_clr");

    // Ordered fill: almost_full at 12, full at 16
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 60'h0_0000001_00000000 | W'(i), "fill");

    // Overflow write is dropped
    step(1'b1, 1'b0, 60'hFFF_FFFF_FFFF_FFFF, "overflow");
    check("overflow.depth", 64'(sb.size()), 64'd16);

    // Simultaneous at full: only the read happens
    step(1'b1, 1'b1, 60'h0_0000BAD_0000BAD0, "simul_full");

    // Drain, then one extra read on empty
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0, "drain");
    step(1'b0, 1'b1, '0, "drain_extra");

    // Underflow: q holds 0xABC through three empty reads
    step(1'b1, 1'b0, 60'hABC, "uf_wr");
    step(1'b0, 1'b1, '0, "uf_rd");
    check("uf.q_abc", 64'(q), 64'hABC);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "underflow");

    // Simultaneous on empty: only the write happens
    step(1'b1, 1'b1, 60'h5, "simul_empty");
    step(1'b0, 1'b1, '0, "simul_empty_rd");
    check("simul_empty.q5", 64'(q), 64'h5);

    // Wrap-around stream, occupancy kept at 8 or below
    written = 0;
    rd_cnt  = 0;
    budget  = 0;
    while ((written < 40 || sb.size() > 0) && budget < 1000) begin
      logic w, r;
      w = (written < 40) && (sb.size() < 8) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0);
      next_w = 60'h0_0000003_00000000 | W'($urandom) | (W'(written) << 40);
      if (r && sb.size() > 0) rd_cnt++;
      if (w) written++;
      step(w, r, next_w, "wrap");
      budget++;
    end
    check("wrap.done", 64'(budget < 1000), 64'd1);
    check("wrap.reads", 64'(rd_cnt), 64'd40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
